// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with parallel load, shift, rotate,
// increment and decrement modes. State updates on the falling clock edge.
//
// Ports:
//   clock    - system clock; all state updates on the falling edge
//   rst_n    - synchronous active-low reset; loads RESET_VALUE and clears carry
//   en       - operation enable; 0 holds q and carry whatever the mode
//   mode     - operation select (hold/load/shl/shr/inc/dec/rol/ror)
//   d        - parallel load data
//   ser_lsb  - serial bit entering bit 0 on shift-left
//   ser_msb  - serial bit entering bit WIDTH-1 on shift-right
//   oe1_n    - bus output enable 1, active-low
//   oe2_n    - bus output enable 2, active-low
//   q        - register contents (registered)
//   bus      - tri-state copy of q; driven only when both enables are low
//   carry    - registered carry/borrow/shifted-out bit
//   zero     - combinational, 1 when q == 0
module universal_register #(
  parameter int unsigned            WIDTH       = 16,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  input  logic             oe1_n,
  input  logic             oe2_n,
  output logic [WIDTH-1:0] q,
  output tri   [WIDTH-1:0] bus,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_INC  = 3'b100;
  localparam logic [2:0] MODE_DEC  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;
  localparam logic [2:0] MODE_ROR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   inc_w;

  // Extra top bit of the widened sum is the wrap-from-all-ones carry.
  assign inc_w = {1'b0, q_q} + (WIDTH + 1)'(1);

  // Next-state: reset first, then enable, then mode.
  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (!rst_n) begin
      q_d     = RESET_VALUE;
      carry_d = 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        MODE_LOAD: begin
          q_d     = d;
          carry_d = 1'b0;
        end
        MODE_SHL: begin
          q_d     = {q_q[WIDTH-2:0], ser_lsb};
          carry_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d     = {ser_msb, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        MODE_INC: begin
          q_d     = inc_w[WIDTH-1:0];
          carry_d = inc_w[WIDTH];
        end
        MODE_DEC: begin
          q_d     = q_q - WIDTH'(1);
          carry_d = (q_q == '0);
        end
        MODE_ROL: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  // State register on the falling edge.
  always_ff @(negedge clock) begin
    q_q     <= q_d;
    carry_q <= carry_d;
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign zero  = (q_q == '0);

  // Bus is driven only when both active-low enables are asserted.
  assign bus = (!oe1_n && !oe2_n) ? q_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_universal_register.sv
module tb_universal_register;

  logic       clock;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       ser_lsb;
  logic       ser_msb;
  logic       oe1_n;
  logic       oe2_n;
  logic [7:0] q, q_b;
  wire  [7:0] bus, bus_b;
  logic       carry, carry_b;
  logic       zero, zero_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clock(clock), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .oe1_n(oe1_n), .oe2_n(oe2_n),
    .q(q), .bus(bus), .carry(carry), .zero(zero)
  );

  universal_register #(.WIDTH(8), .RESET_VALUE(8'hC3)) dut_c3 (
    .clock(clock), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .oe1_n(oe1_n), .oe2_n(oe2_n),
    .q(q_b), .bus(bus_b), .carry(carry_b), .zero(zero_b)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  // Apply controls, then advance past the next falling edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dd, input logic sl, input logic sm);
    rst_n = r; en = e; mode = m; d = dd; ser_lsb = sl; ser_msb = sm;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h00) $display("FAIL initial_reset_q: got %h want 00", q); else pass_cnt++;
    step(1'b1, 1'b1, 3'b001, 8'hAD, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h5A) $display("FAIL pre_reset_q: got %h want 5a", q); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL pre_reset_carry: got %b want 1", carry); else pass_cnt++;
    total_cnt++; if (q_b !== 8'h5A) $display("FAIL pre_reset_q_c3: got %h want 5a", q_b); else pass_cnt++;
    step(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL reset_carry: got %b want 0", carry); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else pass_cnt++;
    total_cnt++; if (q_b !== 8'hC3) $display("FAIL reset_q_c3: got %h want c3", q_b); else pass_cnt++;
    total_cnt++; if (carry_b !== 1'b0) $display("FAIL reset_carry_c3: got %b want 0", carry_b); else pass_cnt++;
    total_cnt++; if (zero_b !== 1'b0) $display("FAIL reset_zero_c3: got %b want 0", zero_b); else pass_cnt++;
  endtask

  task automatic test_load_hold();
    step(1'b1, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'hA5) $display("FAIL load_q: got %h want a5", q); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL load_carry: got %b want 0", carry); else pass_cnt++;
    total_cnt++; if (zero !== 1'b0) $display("FAIL load_zero: got %b want 0", zero); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 3'b100, 8'h00, 1'b1, 1'b1);
      total_cnt++; if (q !== 8'hA5) $display("FAIL en0_hold_q[%0d]: got %h want a5", i, q); else pass_cnt++;
    end
    // mode 000 with en=1 must also hold, including a set carry
    step(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b000, 8'hFF, 1'b1, 1'b1);
    total_cnt++; if (q !== 8'h4A) $display("FAIL mode_hold_q: got %h want 4a", q); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL mode_hold_carry: got %b want 1", carry); else pass_cnt++;
  endtask

  task automatic test_count_wrap();
    step(1'b1, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'hFF || carry !== 1'b0) $display("FAIL inc_ff: got q=%h c=%b want ff/0", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h00 || carry !== 1'b1) $display("FAIL inc_wrap: got q=%h c=%b want 00/1", q, carry); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL inc_wrap_zero: got %b want 1", zero); else pass_cnt++;
    step(1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'hFF || carry !== 1'b1) $display("FAIL dec_wrap: got q=%h c=%b want ff/1", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'hFE || carry !== 1'b0) $display("FAIL dec_fe: got q=%h c=%b want fe/0", q, carry); else pass_cnt++;
  endtask

  task automatic test_shift_rotate();
    step(1'b1, 1'b1, 3'b001, 8'b1001_0110, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b010, 8'h00, 1'b1, 1'b1);
    total_cnt++; if (q !== 8'b0010_1101 || carry !== 1'b1) $display("FAIL shl: got q=%b c=%b want 00101101/1", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (q !== 8'b0001_0110 || carry !== 1'b1) $display("FAIL shr: got q=%b c=%b want 00010110/1", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b110, 8'h00, 1'b1, 1'b1);
    total_cnt++; if (q !== 8'b0010_1100 || carry !== 1'b0) $display("FAIL rol: got q=%b c=%b want 00101100/0", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b111, 8'h00, 1'b1, 1'b1);
    total_cnt++; if (q !== 8'b0001_0110 || carry !== 1'b0) $display("FAIL ror: got q=%b c=%b want 00010110/0", q, carry); else pass_cnt++;
    // ser_msb=1 entering on shift-right, rotate carrying a 1 around
    step(1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
    total_cnt++; if (q !== 8'b1000_1011 || carry !== 1'b0) $display("FAIL shr_ser1: got q=%b c=%b want 10001011/0", q, carry); else pass_cnt++;
    step(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'b0001_0111 || carry !== 1'b1) $display("FAIL rol_msb1: got q=%b c=%b want 00010111/1", q, carry); else pass_cnt++;
  endtask

  task automatic test_tristate();
    oe1_n = 1'b0; oe2_n = 1'b0;
    step(1'b1, 1'b1, 3'b001, 8'h3C, 1'b0, 1'b0);
    total_cnt++; if (bus !== 8'h3C) $display("FAIL bus_on: got %h want 3c", bus); else pass_cnt++;
    oe1_n = 1'b1; #1;
    total_cnt++; if (bus === 8'h3C) $display("FAIL bus_off_oe1: got %h want zz", bus); else pass_cnt++;
    oe1_n = 1'b0; oe2_n = 1'b1; #1;
    total_cnt++; if (bus === 8'h3C) $display("FAIL bus_off_oe2: got %h want zz", bus); else pass_cnt++;
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h3D) $display("FAIL oe_count_3d: got %h want 3d", q); else pass_cnt++;
    oe1_n = 1'b0; oe2_n = 1'b0;
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h3E || bus !== 8'h3E) $display("FAIL oe_count_3e: got q=%h bus=%h want 3e", q, bus); else pass_cnt++;
  endtask

  task automatic test_reset_mid_count();
    step(1'b1, 1'b1, 3'b001, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h15) $display("FAIL mid_count: got %h want 15", q); else pass_cnt++;
    step(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h00 || bus !== 8'h00) $display("FAIL mid_reset: got q=%h bus=%h want 00", q, bus); else pass_cnt++;
    step(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    total_cnt++; if (q !== 8'h01 || carry !== 1'b0) $display("FAIL resume: got q=%h c=%b want 01/0", q, carry); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00;
    ser_lsb = 1'b0; ser_msb = 1'b0; oe1_n = 1'b1; oe2_n = 1'b1;
    test_reset();
    test_load_hold();
    test_count_wrap();
    test_shift_rotate();
    test_tristate();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised successor of the 4-bit load-enable D register: WIDTH-bit register with parallel load, shift, rotate, increment and decrement modes.
- Registered carry/shift-out flag, combinational zero flag, and a tri-state bus driver gated by active-low output enables.
- Used for general-purpose and counting registers (accumulator, address counters, serial conversion) in the 16-bit datapath.

Parameters:
- WIDTH, 16, register width in bits (legal range 2..64).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clock  input  1  system clock; all state updates on the FALLING edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  operation enable; 0 forces hold regardless of mode.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- ser_lsb  input  1  serial bit shifted into bit 0 on shift-left.
- ser_msb  input  1  serial bit shifted into bit WIDTH-1 on shift-right.
- oe1_n  input  1  output enable 1, active-low.
- oe2_n  input  1  output enable 2, active-low.
- q  output  WIDTH  register contents, always driven.
- bus  output  WIDTH  tri-state copy of q.
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  combinational, 1 when q == 0.

Behaviour:
- All updates occur on negedge clock. Priority: rst_n, then en, then mode.
- Reset (rst_n=0 at falling edge): q <= RESET_VALUE, carry <= 0. Reset overrides en and mode. Asserting reset mid-sequence (e.g. while counting) takes effect at that edge; there is no partial state.
- en=0: q and carry hold.
- en=1, mode:
  - 000 hold: q and carry unchanged.
  - 001 load: q <= d; carry <= 0.
  - 010 shift left: q <= {q[WIDTH-2:0], ser_lsb}; carry <= q[WIDTH-1].
  - 011 shift right: q <= {ser_msb, q[WIDTH-1:1]}; carry <= q[0].
  - 100 increment: q <= q+1 mod 2^WIDTH; carry <= 1 only when q was all ones (wrap to 0), else 0.
  - 101 decrement: q <= q-1 mod 2^WIDTH; carry <= 1 only when q was 0 (wrap to all ones), else 0.
  - 110 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; carry <= q[WIDTH-1].
  - 111 rotate right: q <= {q[0], q[WIDTH-1:1]}; carry <= q[0].
- All arithmetic is unsigned and truncated to WIDTH bits. No saturation.
- Latency: one falling edge from control/data setup to updated q/carry. zero follows q combinationally, with the same-cycle visibility as q.
- bus = q when (oe1_n==0 && oe2_n==0); otherwise bus is all high-impedance. oe has no effect on q, carry or state. bus is high-Z during reset unless both enables are low, in which case it shows q.
- Inputs are sampled only at the falling edge. Changes to mode/d/ser_* between edges have no effect.
- No X propagation permitted: q and carry must be defined after the first reset edge.

Test Plan (WIDTH=8, RESET_VALUE=0 unless stated):
- Reset: q=8'h5A, carry=1, rst_n=0 with en=1, mode=100 for one falling edge -> q=8'h00, carry=0, zero=1. Repeat with RESET_VALUE=8'hC3 -> q=8'hC3.
- Load and hold: mode=001, d=8'hA5, en=1 -> q=8'hA5, carry=0. Then en=0, mode=100 for 3 edges -> q stays 8'hA5.
- Count wrap: load 8'hFE, then mode=100 for 2 edges -> q=8'hFF, carry=0, then q=8'h00, carry=1, zero=1. Then mode=101 for 1 edge -> q=8'hFF, carry=1. One more edge -> q=8'hFE, carry=0.
- Shift/rotate: load 8'b1001_0110.
  - mode=010, ser_lsb=1 -> q=8'b0010_1101, carry=1.
  - mode=011, ser_msb=0 -> q=8'b0001_0110, carry=1.
  - mode=110 -> q=8'b0010_1100, carry=0.
  - mode=111 -> q=8'b0001_0110, carry=0.
- Tri-state: q=8'h3C.
  - oe1_n=0, oe2_n=0 -> bus=8'h3C.
  - oe1_n=1 or oe2_n=1 -> bus=8'hZZ.
  - Toggling oe during increment does not alter the count sequence 3C, 3D, 3E.
- Reset mid-operation: load 8'h10, increment 5 edges (q=8'h15), assert rst_n=0 for one edge with mode=100 -> q=8'h00. Deassert -> counting resumes 8'h01 on the next edge.
